// File: rtl/run_timer_pkg.sv
// Shared constants for the run_timer stopwatch: FSM state encoding,
// BCD digit width and the 9:59.9 saturation value.
package run_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [15:0] SAT_TIME = 16'h9599;
  localparam logic [15:0] LAST_BEFORE_SAT = SAT_TIME - 16'h0001;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/run_timer_bcd_digit.sv
// One BCD digit that wraps at MAX_VAL; advances when inc is high and
// reports a combinational carry on the wrapping step.
module bcd_digit
  import run_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_VAL = 4'd9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  assign carry = inc && (digit == MAX_VAL);

  // digit register: reset/clear to zero, otherwise step with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= {DIGIT_W{1'b0}};
    end else if (clear) begin
      digit <= {DIGIT_W{1'b0}};
    end else if (inc) begin
      digit <= carry ? {DIGIT_W{1'b0}} : digit + 1'b1;
    end else begin
      digit <= digit;
    end
  end

endmodule

// File: rtl/run_timer.sv
// Stopwatch 0:00.0 .. 9:59.9 in BCD with pause/resume and saturation.
// Optional lap capture register is built only with RUN_TIMER_LAP_EN defined.
module run_timer
  import run_timer_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] time_bcd,
  output logic [15:0] lap_bcd,
  output logic        running,
  output logic        done
);

  localparam int PW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_DIGIT - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [PW-1:0] presc;
  logic          count_en;
  logic          step;
  logic          c_tenths;
  logic          c_ones;
  logic          c_tens;
  logic          min_carry_unused;

  // Ticks on a cycle that leaves RUN (pause/clear) are dropped.
  assign count_en = tick && (state == ST_RUN) && !pause && !clear;
  assign step     = count_en && (presc == PRESC_MAX);

  // next-state logic, priority clear > pause > start
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!pause && start) state_nxt = ST_RUN;
          else                 state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (pause)                                        state_nxt = ST_PAUSED;
          else if (step && (time_bcd == LAST_BEFORE_SAT))   state_nxt = ST_DONE;
          else                                              state_nxt = ST_RUN;
        end
        ST_PAUSED: begin
          if (!pause && start) state_nxt = ST_RUN;
          else                 state_nxt = ST_PAUSED;
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // state plus registered status decodes
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
    end
  end

  // prescaler: divides ticks down to 0.1 s steps, holds outside RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= {PW{1'b0}};
    end else if (clear) begin
      presc <= {PW{1'b0}};
    end else if (count_en) begin
      presc <= (presc == PRESC_MAX) ? {PW{1'b0}} : presc + 1'b1;
    end else begin
      presc <= presc;
    end
  end

  bcd_digit #(.MAX_VAL(4'd9)) u_tenths (
    .clk(clk), .reset(reset), .clear(clear), .inc(step),
    .digit(time_bcd[3:0]), .carry(c_tenths)
  );
  bcd_digit #(.MAX_VAL(4'd9)) u_sec_ones (
    .clk(clk), .reset(reset), .clear(clear), .inc(c_tenths),
    .digit(time_bcd[7:4]), .carry(c_ones)
  );
  bcd_digit #(.MAX_VAL(4'd5)) u_sec_tens (
    .clk(clk), .reset(reset), .clear(clear), .inc(c_ones),
    .digit(time_bcd[11:8]), .carry(c_tens)
  );
  bcd_digit #(.MAX_VAL(4'd9)) u_min (
    .clk(clk), .reset(reset), .clear(clear), .inc(c_tens),
    .digit(time_bcd[15:12]), .carry(min_carry_unused)
  );

`ifdef RUN_TIMER_LAP_EN
  // lap capture sees the pre-clear time when lap and clear coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_bcd <= 16'h0000;
    end else if (lap && (state != ST_IDLE)) begin
      lap_bcd <= time_bcd;
    end else begin
      lap_bcd <= lap_bcd;
    end
  end
`else
  logic lap_unused;
  assign lap_unused = lap;
  assign lap_bcd    = 16'h0000;
`endif

endmodule

// File: tb/tb_run_timer.sv
// Table-driven self-checking bench for run_timer (TICKS_PER_DIGIT = 4)
// with a scoreboard queue of expected outputs.
module tb_run_timer;

  localparam int T = 4;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic        pause;
  logic        clear;
  logic        lap;
  logic [15:0] time_bcd;
  logic [15:0] lap_bcd;
  logic        running;
  logic        done;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        s, p, c, l, ct;
    int          n;
    logic [15:0] t;
    logic        r, d;
    logic [15:0] lp;
  } vec_t;

  typedef struct {
    logic [15:0] t;
    logic        r, d;
    logic [15:0] lp;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[20];

  run_timer #(.TICKS_PER_DIGIT(T)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .clear(clear), .lap(lap), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
    .running(running), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lapv(input logic [15:0] x);
`ifdef RUN_TIMER_LAP_EN
    return x;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic vec_t mk(input logic s, p, c, l, ct, input int n,
                              input logic [15:0] t, input logic r, d,
                              input logic [15:0] lp);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.l = l; v.ct = ct; v.n = n;
    v.t = t; v.r = r; v.d = d; v.lp = lp;
    return v;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] t, input logic r, d, input logic [15:0] lp);
    exp_t e;
    e.t = t; e.r = r; e.d = d; e.lp = lp;
    sbq.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: scoreboard empty, got none expected one entry", tag);
    end else begin
      e = sbq.pop_front();
      cmp({tag, ".time_bcd"}, time_bcd, e.t);
      cmp({tag, ".running"}, {15'd0, running}, {15'd0, e.r});
      cmp({tag, ".done"}, {15'd0, done}, {15'd0, e.d});
      cmp({tag, ".lap_bcd"}, lap_bcd, e.lp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    start = v.s; pause = v.p; clear = v.c; lap = v.l; tick = v.ct;
    cyc();
    start = 1'b0; pause = 1'b0; clear = 1'b0; lap = 1'b0; tick = 1'b0;
    ticks(v.n);
    push_exp(v.t, v.r, v.d, v.lp);
    check_out(tag);
  endtask

  initial begin
    //                s     p     c     l     ct    n      time      r     d     lap
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8,     16'h0002, 1'b1, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,     16'h0000, 1'b0, 1'b0, 16'h0000);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6,     16'h0001, 1'b1, 1'b0, 16'h0000);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5,     16'h0001, 1'b0, 1'b0, 16'h0000);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2,     16'h0002, 1'b1, 1'b0, 16'h0000);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,     16'h0000, 1'b0, 1'b0, 16'h0000);
    vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 599*T, 16'h0599, 1'b1, 1'b0, 16'h0000);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,     16'h1000, 1'b1, 1'b0, 16'h0000);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3,     16'h1000, 1'b0, 1'b0, 16'h0000);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3,     16'h1000, 1'b1, 1'b0, 16'h0000);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,     16'h1001, 1'b1, 1'b0, 16'h0000);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,     16'h0000, 1'b0, 1'b0, 16'h0000);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13*T,  16'h0013, 1'b1, 1'b0, 16'h0000);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,     16'h0015, 1'b1, 1'b0, lapv(16'h0013));
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0,     16'h0000, 1'b0, 1'b0, lapv(16'h0015));
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5999*T, 16'h9599, 1'b0, 1'b1, lapv(16'h0015));
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 100,   16'h9599, 1'b0, 1'b1, lapv(16'h0015));
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4,     16'h9599, 1'b0, 1'b1, lapv(16'h0015));
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0,     16'h9599, 1'b0, 1'b1, lapv(16'h9599));
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,     16'h0000, 1'b0, 1'b0, lapv(16'h9599));

    reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; lap = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    push_exp(16'h0000, 1'b0, 1'b0, 16'h0000);
    check_out("reset");

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // reset mid-count: partial interval and captured lap are discarded
    start = 1'b1;
    cyc();
    start = 1'b0;
    ticks(6);
    reset = 1'b1; tick = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0;
    push_exp(16'h0000, 1'b0, 1'b0, 16'h0000);
    check_out("midreset");

    start = 1'b1;
    cyc();
    start = 1'b0;
    ticks(2);
    push_exp(16'h0000, 1'b1, 1'b0, 16'h0000);
    check_out("presc_zeroed");
    ticks(2);
    push_exp(16'h0001, 1'b1, 1'b0, 16'h0000);
    check_out("after_reset_count");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
